// File: rtl/ans_histogram_pkg.sv
// Shared constants for the ANS histogram front end and the ANS core sequencer.
// State encoding and command codes live here so every block agrees on them.
package ans_histogram_pkg;

    localparam int SYM_WIDTH = 4;
    localparam int CNT_WIDTH = 4;
    localparam int NUM_SYMS  = 2 ** SYM_WIDTH;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'b00,
        ST_EMIT    = 2'b01,
        ST_HEADER  = 2'b10
    } hist_state_t;

    // Core command codes, shared with the system-level sequencer.
    localparam logic [1:0] CMD_ENC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;
    localparam logic [1:0] CMD_LOAD = 2'b11;

endpackage

// File: rtl/ans_hist_table.sv
// Count register file for the histogram: increment, read and clear ports.
// With ANS_HIST_HEADER_EN it also reports whether the incremented entry was empty.
module ans_hist_table #(
    parameter int SYM_WIDTH = ans_histogram_pkg::SYM_WIDTH,
    parameter int CNT_WIDTH = ans_histogram_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SYM_WIDTH-1:0] inc_sym,
    input  logic                 inc_en,
`ifdef ANS_HIST_HEADER_EN
    output logic                 inc_zero,
`endif
    input  logic [SYM_WIDTH-1:0] rd_idx,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    input  logic [SYM_WIDTH-1:0] clr_idx,
    input  logic                 clr_en
);
    import ans_histogram_pkg::*;

    localparam int ENTRIES = 2 ** SYM_WIDTH;

    logic [CNT_WIDTH-1:0] counts [ENTRIES];

    assign rd_cnt = counts[rd_idx];
`ifdef ANS_HIST_HEADER_EN
    assign inc_zero = (counts[inc_sym] == '0);
`endif

    // Increment and clear never coincide: symbols are only accepted while collecting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) counts[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (clr_en && clr_idx == SYM_WIDTH'(i))
                    counts[i] <= '0;
                else if (inc_en && inc_sym == SYM_WIDTH'(i))
                    counts[i] <= counts[i] + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ans_histogram.sv
// Symbol histogram feeding the ANS core load path: counts a block, then streams
// the table as a valid/ready stream. ANS_HIST_HEADER_EN adds a leading header beat.
module ans_histogram #(
    parameter int SYM_WIDTH = ans_histogram_pkg::SYM_WIDTH,
    parameter int CNT_WIDTH = ans_histogram_pkg::CNT_WIDTH,
    parameter int BLOCK_LEN = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SYM_WIDTH-1:0] sym_in,
    input  logic                 sym_vld,
    input  logic                 sym_last,
    output logic                 sym_rdy,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 cnt_vld,
    input  logic                 cnt_rdy,
    output logic                 busy
);
    import ans_histogram_pkg::*;

    localparam int ENTRIES = 2 ** SYM_WIDTH;
    localparam int N_W     = $clog2(BLOCK_LEN + 1);

    hist_state_t          state, state_nxt;
    logic [N_W-1:0]       n;
    logic [SYM_WIDTH-1:0] idx;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic                 sym_acc, cnt_acc, blk_end, tbl_done;

    assign sym_acc  = sym_vld && sym_rdy;
    assign cnt_acc  = cnt_vld && cnt_rdy;
    assign blk_end  = sym_acc && (sym_last || n == N_W'(BLOCK_LEN - 1));
    assign tbl_done = (state == ST_EMIT) && cnt_acc && (idx == SYM_WIDTH'(ENTRIES - 1));

`ifdef ANS_HIST_HEADER_EN
    logic                 inc_zero;
    logic [CNT_WIDTH-1:0] nz;
`endif

    ans_hist_table #(
        .SYM_WIDTH(SYM_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .inc_sym(sym_in),
        .inc_en (sym_acc),
`ifdef ANS_HIST_HEADER_EN
        .inc_zero(inc_zero),
`endif
        .rd_idx (idx),
        .rd_cnt (rd_cnt),
        .clr_idx(idx),
        .clr_en (cnt_acc && state == ST_EMIT)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_COLLECT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: begin
`ifdef ANS_HIST_HEADER_EN
                if (blk_end) state_nxt = ST_HEADER;
`else
                if (blk_end) state_nxt = ST_EMIT;
`endif
            end
            ST_HEADER: if (cnt_acc) state_nxt = ST_EMIT;
            ST_EMIT:   if (tbl_done) state_nxt = ST_COLLECT;
            default:   state_nxt = ST_COLLECT;
        endcase
    end

    always_comb begin
        sym_rdy = 1'b0;
        cnt_vld = 1'b0;
        busy    = 1'b0;
        cnt_out = '0;
        case (state)
            ST_COLLECT: sym_rdy = 1'b1;
            ST_EMIT: begin
                cnt_vld = 1'b1;
                busy    = 1'b1;
                cnt_out = rd_cnt;
            end
            ST_HEADER: begin
                cnt_vld = 1'b1;
                busy    = 1'b1;
`ifdef ANS_HIST_HEADER_EN
                cnt_out = nz - CNT_WIDTH'(1);
`endif
            end
            default: sym_rdy = 1'b0;
        endcase
    end

    // n restarts at block end; idx wraps to 0 naturally after the last entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n   <= '0;
            idx <= '0;
        end else begin
            if (blk_end)      n <= '0;
            else if (sym_acc) n <= n + N_W'(1);
            if (state == ST_EMIT && cnt_acc) idx <= idx + SYM_WIDTH'(1);
        end
    end

`ifdef ANS_HIST_HEADER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      nz <= '0;
        else if (tbl_done)            nz <= '0;
        else if (sym_acc && inc_zero) nz <= nz + CNT_WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_ans_histogram.sv
// Directed bench for ans_histogram: full/early blocks, backpressure, self-clear,
// reset mid-emit and (with ANS_HIST_HEADER_EN) the header beat.
module tb_ans_histogram;

`ifdef ANS_HIST_HEADER_EN
    localparam int NB   = 17;
    localparam int HOFF = 1;
`else
    localparam int NB   = 16;
    localparam int HOFF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sym_in;
    logic       sym_vld, sym_last, sym_rdy;
    logic [3:0] cnt_out;
    logic       cnt_vld, cnt_rdy, busy;

    int n_chk  = 0;
    int n_pass = 0;
    int model [16];
    int got [17];
    int nbeat;
    int lowcyc;

    ans_histogram dut (
        .clk     (clk),
        .rst     (rst),
        .sym_in  (sym_in),
        .sym_vld (sym_vld),
        .sym_last(sym_last),
        .sym_rdy (sym_rdy),
        .cnt_out (cnt_out),
        .cnt_vld (cnt_vld),
        .cnt_rdy (cnt_rdy),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input bit last);
        sym_in   = 4'(s);
        sym_vld  = 1'b1;
        sym_last = last;
        chk("sym_rdy_collect", int'(sym_rdy), 1);
        tick();
        sym_vld  = 1'b0;
        sym_last = 1'b0;
        model[s]++;
    endtask

    // mode 0: cnt_rdy held high; mode 1: cnt_rdy toggles 0/1 every cycle
    task automatic drain(input int mode, input int stop_after);
        int held;
        held   = -1;
        nbeat  = 0;
        lowcyc = 0;
        for (int c = 0; c < 400 && nbeat < stop_after; c++) begin
            cnt_rdy = (mode == 0) ? 1'b1 : c[0];
            if (!sym_rdy) lowcyc++;
            if (held >= 0) chk("held_entry", int'(cnt_out), held);
            if (cnt_vld && cnt_rdy) begin
                got[nbeat] = int'(cnt_out);
                nbeat++;
                held = -1;
            end else if (cnt_vld) begin
                held = int'(cnt_out);
            end
            tick();
        end
        cnt_rdy = 1'b0;
    endtask

    task automatic check_table(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 16; i++) if (model[i] != 0) nz++;
        chk($sformatf("%s_beats", tag), nbeat, NB);
`ifdef ANS_HIST_HEADER_EN
        chk($sformatf("%s_header", tag), got[0], nz - 1);
`endif
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_cnt%0d", tag, i), got[i + HOFF], model[i]);
        for (int i = 0; i < 16; i++) model[i] = 0;
    endtask

    initial begin
        rst      = 1'b1;
        sym_in   = '0;
        sym_vld  = 1'b0;
        sym_last = 1'b0;
        cnt_rdy  = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sym_rdy", int'(sym_rdy), 1);
        chk("rst_cnt_vld", int'(cnt_vld), 0);
        chk("rst_cnt_out", int'(cnt_out), 0);
        chk("rst_busy",    int'(busy),    0);
        rst = 1'b0;
        tick();

        // Full block: 15 x symbol 3, ends on length
        for (int i = 0; i < 15; i++) send(3, 1'b0);
        chk("full_first_vld", int'(cnt_vld), 1);
        chk("full_busy",      int'(busy),    1);
        drain(0, NB);
        chk("full_rdy_low_cycles", lowcyc, NB);
        chk("full_rdy_after", int'(sym_rdy), 1);
        chk("full_entry3_hand", got[3 + HOFF], 15);
        check_table("full");

        // Early end: 1,2,2 with last on the third
        send(1, 1'b0); send(2, 1'b0); send(2, 1'b1);
        chk("early_first_vld", int'(cnt_vld), 1);
        drain(0, NB);
        chk("early_entry2_hand", got[2 + HOFF], 2);
        check_table("early");

        // Backpressure on the same block
        send(1, 1'b0); send(2, 1'b0); send(2, 1'b1);
        drain(1, NB);
        chk("bp_vld_after", int'(cnt_vld), 0);
        check_table("bp");

        // Self-clear across two full blocks
        for (int i = 0; i < 15; i++) send(0, 1'b0);
        drain(0, NB);
        check_table("clr_a");
        for (int i = 0; i < 15; i++) send(5, 1'b0);
        drain(0, NB);
        chk("clr_b_entry0_hand", got[0 + HOFF], 0);
        chk("clr_b_entry5_hand", got[5 + HOFF], 15);
        check_table("clr_b");

        // Reset mid-emit after 4 accepted beats
        send(4, 1'b0); send(4, 1'b0); send(8, 1'b1);
        drain(0, 4);
        chk("mid_busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cnt_vld", int'(cnt_vld), 0);
        chk("mid_rst_sym_rdy", int'(sym_rdy), 1);
        chk("mid_rst_busy",    int'(busy),    0);
        chk("mid_rst_cnt_out", int'(cnt_out), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 0;
        tick();
        send(7, 1'b1);
        drain(0, NB);
        chk("mid_entry7_hand", got[7 + HOFF], 1);
        check_table("mid");

`ifdef ANS_HIST_HEADER_EN
        send(0, 1'b0); send(1, 1'b0); send(1, 1'b0); send(9, 1'b1);
        drain(0, NB);
        chk("hdr_value_hand", got[0], 2);
        chk("hdr_entry9_hand", got[10], 1);
        check_table("hdr");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
